// File: rtl/i2s_rx_slave.sv
// i2s_rx_slave
// Serial-to-parallel Philips I2S receiver running entirely on the master clock.
// SCLK, LRCLK and SDIN are oversampled through two-flop synchronisers. Every
// synchronised SCLK rising edge is a "bit event". The receiver locks onto the
// first LRCLK transition, skips the one-bit I2S delay, and then shifts DW bits
// MSB-first into the word for the current channel. Slot bits beyond DW are
// ignored. A slot that ends before DW bits arrive is dropped and flagged.
//
// Ports
//   CLK     in        master clock; every register uses it
//   RST     in        synchronous active-high reset
//   SCLK    in        I2S bit clock (asynchronous)
//   LRCLK   in        word select, 0 = left, 1 = right (asynchronous)
//   SDIN    in        serial data (asynchronous)
//   L_DOUT  out [DW]  last complete left word, held until the next one
//   R_DOUT  out [DW]  last complete right word, held until the next one
//   L_VALID out       one-cycle strobe when L_DOUT updates
//   R_VALID out       one-cycle strobe when R_DOUT updates
//   ERR     out       one-cycle strobe when a short slot was discarded

module i2s_rx_slave #(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SCLK,
    input  logic          LRCLK,
    input  logic          SDIN,
    output logic [DW-1:0] L_DOUT,
    output logic [DW-1:0] R_DOUT,
    output logic          L_VALID,
    output logic          R_VALID,
    output logic          ERR
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    localparam logic [1:0] SEEK  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic          r_sclkS1, r_sclkS2, r_sclkS3;
    logic          r_lrS1, r_lrS2;
    logic          r_sdS1, r_sdS2;
    logic          r_lrPrev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_bitCnt;
    logic [DW-2:0] r_sh;
    logic          r_ch;
    logic [DW-1:0] r_lDout, r_rDout;
    logic          r_lValid, r_rValid, r_err;

    logic          w_bitEvent;
    logic          w_lrChg;
    logic          w_isLast;
    logic          w_inShift;
    logic          w_complete;
    logic          w_shortSlot;
    logic          w_restart;
    logic [DW-1:0] w_word;
    logic [1:0]    w_nextState;

    // Two-flop synchronisers. SCLK gets a third stage so a rising edge can be
    // detected. LRCLK and SDIN use the same depth as the edge detector's
    // newer stage, so all three stay aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sclkS1 <= 1'b0;
            r_sclkS2 <= 1'b0;
            r_sclkS3 <= 1'b0;
            r_lrS1   <= 1'b0;
            r_lrS2   <= 1'b0;
            r_sdS1   <= 1'b0;
            r_sdS2   <= 1'b0;
        end else begin
            r_sclkS1 <= SCLK;
            r_sclkS2 <= r_sclkS1;
            r_sclkS3 <= r_sclkS2;
            r_lrS1   <= LRCLK;
            r_lrS2   <= r_lrS1;
            r_sdS1   <= SDIN;
            r_sdS2   <= r_sdS1;
        end
    end

    // Event decode for the current cycle.
    // A word completes on its LSB whether or not LRCLK flips on that same
    // edge, because an exact DW-bit slot puts its LSB on the transition.
    // A flip on any earlier bit means the slot was short.
    always_comb begin
        w_bitEvent  = r_sclkS2 & ~r_sclkS3;
        w_lrChg     = (r_lrS2 != r_lrPrev);
        w_isLast    = (r_bitCnt == LAST_BIT);
        w_inShift   = (r_state == SHIFT);
        w_word      = {r_sh, r_sdS2};
        w_complete  = w_bitEvent & w_inShift & w_isLast;
        w_shortSlot = w_bitEvent & w_inShift & w_lrChg & ~w_isLast;
        w_restart   = w_bitEvent & w_lrChg;
        w_nextState = r_state;
        if (w_restart) begin
            w_nextState = SHIFT;
        end else if (w_complete) begin
            w_nextState = HOLD;
        end else if (r_state == 2'd3) begin
            w_nextState = SEEK;
        end
    end

    // Framing state, bit counter, shift register and channel tracking.
    // A restart always reloads the counter and channel from the new LRCLK
    // level, so the counter never needs to wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= SEEK;
            r_lrPrev <= 1'b0;
            r_bitCnt <= '0;
            r_sh     <= '0;
            r_ch     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_bitEvent) begin
                r_lrPrev <= r_lrS2;
            end
            if (w_restart) begin
                r_bitCnt <= '0;
                r_ch     <= r_lrS2;
            end else if (w_bitEvent && w_inShift && !w_isLast) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (w_shortSlot) begin
                r_sh <= '0;
            end else if (w_bitEvent && w_inShift) begin
                r_sh <= w_word[DW-2:0];
            end
        end
    end

    // Output words and strobes. Only the channel being completed is touched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lDout  <= '0;
            r_rDout  <= '0;
            r_lValid <= 1'b0;
            r_rValid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_lValid <= 1'b0;
            r_rValid <= 1'b0;
            r_err    <= w_shortSlot;
            if (w_complete) begin
                if (r_ch) begin
                    r_rDout  <= w_word;
                    r_rValid <= 1'b1;
                end else begin
                    r_lDout  <= w_word;
                    r_lValid <= 1'b1;
                end
            end
        end
    end

    assign L_DOUT  = r_lDout;
    assign R_DOUT  = r_rDout;
    assign L_VALID = r_lValid;
    assign R_VALID = r_rValid;
    assign ERR     = r_err;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// tb_i2s_rx_slave
// Drives Philips I2S frames into two receivers, one with DW=16 and one with
// DW=24, from the same serial lines. Each slot pushes the strobe it should
// produce, if any, into a per-receiver queue. Monitors pop and compare
// entries as strobes appear. Table records cover uniform streams. Hand
// sequences cover the short slot and the mid-word reset.

`timescale 1ns/1ps

module tb_i2s_rx_slave;

    localparam int KIND_L   = 0;
    localparam int KIND_R   = 1;
    localparam int KIND_ERR = 2;

    localparam int EXP_NONE  = 0;
    localparam int EXP_VALID = 1;
    localparam int EXP_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } sbItem_t;

    typedef struct {
        logic [31:0] lBits;
        logic [31:0] rBits;
        int          lLen;
        int          rLen;
        int          frames;
        logic [31:0] expL16;
        logic [31:0] expR16;
        logic [31:0] expL24;
        logic [31:0] expR24;
        int          nL16;
        int          nR16;
        int          nE16;
        int          nL24;
        int          nR24;
        int          nE24;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        lrclk;
    logic        sdin;
    logic [15:0] lDout16, rDout16;
    logic        lValid16, rValid16, err16;
    logic [23:0] lDout24, rDout24;
    logic        lValid24, rValid24, err24;

    sbItem_t q16[$];
    sbItem_t q24[$];
    int      checks;
    int      errors;
    int      cntL16, cntR16, cntE16;
    int      cntL24, cntR24, cntE24;
    logic    pendingBit;
    vec_t    vecs[4];

    i2s_rx_slave #(.DW(16)) dut16 (
        .CLK(clk), .RST(rst), .SCLK(sclk), .LRCLK(lrclk), .SDIN(sdin),
        .L_DOUT(lDout16), .R_DOUT(rDout16),
        .L_VALID(lValid16), .R_VALID(rValid16), .ERR(err16)
    );

    i2s_rx_slave #(.DW(24)) dut24 (
        .CLK(clk), .RST(rst), .SCLK(sclk), .LRCLK(lrclk), .SDIN(sdin),
        .L_DOUT(lDout24), .R_DOUT(rDout24),
        .L_VALID(lValid24), .R_VALID(rValid24), .ERR(err24)
    );

    // 100 MHz master clock; SCLK is generated at CLK/8.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a failure line.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Strobe scoreboard for the 16-bit receiver.
    always @(negedge clk) begin
        if (!rst && (lValid16 || rValid16 || err16)) begin
            sbItem_t it;
            int      actKind;
            logic [31:0] actData;
            checkOutput("strobeOverlap16",
                        int'(lValid16) + int'(rValid16) + int'(err16), 1);
            actKind = lValid16 ? KIND_L : (rValid16 ? KIND_R : KIND_ERR);
            actData = lValid16 ? {16'h0, lDout16} : {16'h0, rDout16};
            if (lValid16) cntL16++;
            if (rValid16) cntR16++;
            if (err16)    cntE16++;
            if (q16.size() == 0) begin
                checkOutput("unexpectedStrobe16", 32'(actKind), 32'hFFFF_FFFF);
            end else begin
                it = q16.pop_front();
                checkOutput("kind16", 32'(actKind), 32'(it.kind));
                if (it.kind != KIND_ERR) begin
                    checkOutput("data16", actData, it.data);
                end
            end
        end
    end

    // Strobe scoreboard for the 24-bit receiver.
    always @(negedge clk) begin
        if (!rst && (lValid24 || rValid24 || err24)) begin
            sbItem_t it;
            int      actKind;
            logic [31:0] actData;
            checkOutput("strobeOverlap24",
                        int'(lValid24) + int'(rValid24) + int'(err24), 1);
            actKind = lValid24 ? KIND_L : (rValid24 ? KIND_R : KIND_ERR);
            actData = lValid24 ? {8'h0, lDout24} : {8'h0, rDout24};
            if (lValid24) cntL24++;
            if (rValid24) cntR24++;
            if (err24)    cntE24++;
            if (q24.size() == 0) begin
                checkOutput("unexpectedStrobe24", 32'(actKind), 32'hFFFF_FFFF);
            end else begin
                it = q24.pop_front();
                checkOutput("kind24", 32'(actKind), 32'(it.kind));
                if (it.kind != KIND_ERR) begin
                    checkOutput("data24", actData, it.data);
                end
            end
        end
    end

    // What a slot of 'len' SCLKs should yield for a receiver of width 'dw'.
    // The first slot after reset carries no LRCLK change, so it is skipped.
    // An exact or short slot only resolves when a following slot flips LRCLK.
    function automatic int expFor(input int len, input int dw,
                                  input bit first, input bit last);
        if (first)     return EXP_NONE;
        if (len > dw)  return EXP_VALID;
        if (last)      return EXP_NONE;
        if (len == dw) return EXP_VALID;
        return EXP_ERR;
    endfunction

    task automatic clearCounts();
        cntL16 = 0; cntR16 = 0; cntE16 = 0;
        cntL24 = 0; cntR24 = 0; cntE24 = 0;
    endtask

    // One SCLK period: data and word select change while SCLK is low.
    task automatic sendBit(input logic lr, input logic sd);
        lrclk = lr;
        sdin  = sd;
        #40;
        sclk  = 1'b1;
        #40;
        sclk  = 1'b0;
    endtask

    // One slot: the delay bit carries the previous slot's last bit, then the
    // slot payload MSB-first, zero padded past 32 bits.
    task automatic sendSlot(input logic lr, input logic [31:0] bits,
                            input int len, input int e16, input int e24);
        sbItem_t it;
        if (e16 != EXP_NONE) begin
            it.kind = (e16 == EXP_ERR) ? KIND_ERR : int'(lr);
            it.data = {16'h0, bits[31:16]};
            q16.push_back(it);
        end
        if (e24 != EXP_NONE) begin
            it.kind = (e24 == EXP_ERR) ? KIND_ERR : int'(lr);
            it.data = {8'h0, bits[31:8]};
            q24.push_back(it);
        end
        sendBit(lr, pendingBit);
        for (int j = 1; j < len; j++) begin
            sendBit(lr, (j <= 32) ? bits[32 - j] : 1'b0);
        end
        pendingBit = (len <= 32) ? bits[32 - len] : 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdin  = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        pendingBit = 1'b0;
        clearCounts();
    endtask

    task automatic applyStimulus(input vec_t v);
        int  total;
        bit  lr;
        bit  first;
        bit  last;
        int  len;
        logic [31:0] bits;
        total = 2 * v.frames + 1;
        for (int s = 0; s < total; s++) begin
            lr    = (s % 2) == 1;
            bits  = lr ? v.rBits : v.lBits;
            len   = lr ? v.rLen : v.lLen;
            first = (s == 0);
            last  = (s == total - 1);
            sendSlot(lr, bits, len, expFor(len, 16, first, last),
                     expFor(len, 24, first, last));
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic checkQueuesDrained();
        checkOutput("pending16", 32'(q16.size()), 0);
        checkOutput("pending24", 32'(q24.size()), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        sclk   = 1'b0;
        lrclk  = 1'b0;
        sdin   = 1'b0;
        pendingBit = 1'b0;
        clearCounts();

        // lBits, rBits, lLen, rLen, frames, expected holds, expected counts
        vecs[0] = '{32'hA5C3_0000, 32'h1234_0000, 32, 32, 3,
                    32'hA5C3, 32'h1234, 32'hA5C300, 32'h123400,
                    3, 3, 0, 3, 3, 0};
        vecs[1] = '{32'h8001_0000, 32'h7FFE_0000, 16, 16, 3,
                    32'h8001, 32'h7FFE, 32'h0, 32'h0,
                    2, 3, 0, 0, 0, 5};
        vecs[2] = '{32'hF0F0_F0AA, 32'h0F0F_0F55, 32, 32, 2,
                    32'hF0F0, 32'h0F0F, 32'hF0F0F0, 32'h0F0F0F,
                    2, 2, 0, 2, 2, 0};
        vecs[3] = '{32'hFFFF_F000, 32'h0000_0FFF, 20, 20, 2,
                    32'hFFFF, 32'h0000, 32'h0, 32'h0,
                    2, 2, 0, 0, 0, 3};

        // Reset state
        doReset();
        repeat (2) @(negedge clk);
        checkOutput("rstLDout16", {16'h0, lDout16}, 0);
        checkOutput("rstRDout16", {16'h0, rDout16}, 0);
        checkOutput("rstStrobes16", {29'h0, lValid16, rValid16, err16}, 0);
        checkOutput("rstLDout24", {8'h0, lDout24}, 0);

        // Uniform streams from the table
        for (int i = 0; i < 4; i++) begin
            doReset();
            applyStimulus(vecs[i]);
            checkQueuesDrained();
            checkOutput("holdL16", {16'h0, lDout16}, vecs[i].expL16);
            checkOutput("holdR16", {16'h0, rDout16}, vecs[i].expR16);
            checkOutput("holdL24", {8'h0, lDout24}, vecs[i].expL24);
            checkOutput("holdR24", {8'h0, rDout24}, vecs[i].expR24);
            checkOutput("countL16", 32'(cntL16), 32'(vecs[i].nL16));
            checkOutput("countR16", 32'(cntR16), 32'(vecs[i].nR16));
            checkOutput("countE16", 32'(cntE16), 32'(vecs[i].nE16));
            checkOutput("countL24", 32'(cntL24), 32'(vecs[i].nL24));
            checkOutput("countR24", 32'(cntR24), 32'(vecs[i].nR24));
            checkOutput("countE24", 32'(cntE24), 32'(vecs[i].nE24));
        end

        // Data before the first LRCLK change is ignored
        doReset();
        sendSlot(1'b0, 32'hDEAD_0000, 32, EXP_NONE, EXP_NONE);
        repeat (4) @(negedge clk);
        checkOutput("noStrobeBeforeLr", 32'(cntL16 + cntR16 + cntE16), 0);
        sendSlot(1'b1, 32'h55AA_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'hC0DE_0000, 32, EXP_VALID, EXP_VALID);
        repeat (12) @(negedge clk);
        checkQueuesDrained();
        checkOutput("firstLeft16", {16'h0, lDout16}, 32'hC0DE);
        checkOutput("firstLeftCount16", 32'(cntL16), 1);

        // Short left slot is flagged and the next right word still lands
        doReset();
        sendSlot(1'b0, 32'hA5C3_0000, 32, EXP_NONE, EXP_NONE);
        sendSlot(1'b1, 32'h1234_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'hA5C3_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b1, 32'h1234_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'h9999_0000, 8, EXP_ERR, EXP_ERR);
        sendSlot(1'b1, 32'hBEEF_0000, 32, EXP_VALID, EXP_VALID);
        repeat (12) @(negedge clk);
        checkQueuesDrained();
        checkOutput("shortKeepL16", {16'h0, lDout16}, 32'hA5C3);
        checkOutput("shortNextR16", {16'h0, rDout16}, 32'hBEEF);
        checkOutput("shortErr16", 32'(cntE16), 1);
        checkOutput("shortKeepL24", {8'h0, lDout24}, 32'hA5C300);
        checkOutput("shortNextR24", {8'h0, rDout24}, 32'hBEEF00);
        checkOutput("shortErr24", 32'(cntE24), 1);

        // Single-cycle reset in the middle of a left word
        doReset();
        sendSlot(1'b0, 32'hA5C3_0000, 32, EXP_NONE, EXP_NONE);
        sendSlot(1'b1, 32'h1234_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'hA5C3_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b1, 32'h1234_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'h6666_0000, 6, EXP_NONE, EXP_NONE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstL16", {16'h0, lDout16}, 0);
        checkOutput("midRstR16", {16'h0, rDout16}, 0);
        checkOutput("midRstR24", {8'h0, rDout24}, 0);
        checkOutput("midRstStrobes", {26'h0, lValid16, rValid16, err16,
                                      lValid24, rValid24, err24}, 0);
        clearCounts();
        sendSlot(1'b0, 32'h0000_0000, 26, EXP_NONE, EXP_NONE);
        sendSlot(1'b1, 32'hBEEF_0000, 32, EXP_VALID, EXP_VALID);
        sendSlot(1'b0, 32'h1357_9B00, 32, EXP_VALID, EXP_VALID);
        repeat (12) @(negedge clk);
        checkQueuesDrained();
        checkOutput("resumeR16", {16'h0, rDout16}, 32'hBEEF);
        checkOutput("resumeL16", {16'h0, lDout16}, 32'h1357);
        checkOutput("resumeL24", {8'h0, lDout24}, 32'h13579B);
        checkOutput("resumeCountL16", 32'(cntL16), 1);
        checkOutput("resumeCountR16", 32'(cntR16), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_rx_slave.md
# i2s_rx_slave

Serial-to-parallel I2S receiver, the input-side counterpart of the audio output block that drives the CS4334 DAC. It runs on the master clock `CLK` (MCLK domain) and oversamples externally supplied `SCLK`, `LRCLK` and `SDIN`, which come from an ADC or from the board's own I2S clock generator. It deserialises standard Philips I2S frames (MSB-first, one-bit delay, `LRCLK`=0 for left) into 16-bit left and right words with single-cycle valid strobes.

## Interface

**Parameters**
- `DW`, default 16: captured word width in bits, 2..32. Slot bits beyond `DW` are discarded.

**Ports**
- `CLK`, in, 1: master clock; every register uses this clock.
- `RST`, in, 1: synchronous, active-high reset.
- `SCLK`, in, 1: I2S bit clock. Treated as asynchronous and double-synchronised.
- `LRCLK`, in, 1: word select; 0 = left, 1 = right. Double-synchronised.
- `SDIN`, in, 1: serial data. Double-synchronised.
- `L_DOUT`, out, `DW`: last complete left word. Holds its value until the next left word is complete.
- `R_DOUT`, out, `DW`: last complete right word. Same hold behaviour.
- `L_VALID`, out, 1: one-`CLK` pulse when `L_DOUT` updates.
- `R_VALID`, out, 1: one-`CLK` pulse when `R_DOUT` updates.
- `ERR`, out, 1: one-`CLK` pulse when a slot ended short and its word was discarded.

## Operation

**Input synchronisers**
- `SCLK`, `LRCLK` and `SDIN` each pass through 2 flops (`s1`, `s2`).
- `SCLK` has a third flop `s3`.
- `sclk_rise` = `s2 & ~s3`.
- All decisions are made only on cycles where `sclk_rise` = 1. Call these "bit events".

**Bit-event registers**
- `lr_prev` holds the `LRCLK` value sampled at the previous bit event.
- `lr_chg` = (`lr_s2` != `lr_prev`).

**State machine (`SEEK`, `SHIFT`, `HOLD`)**
- `SEEK`: the reset state. Bits are ignored.
  - On a bit event with `lr_chg`, go to `SHIFT` with `bitcnt`=0 and `ch`=`lr_s2`.
  - This bit event is the I2S delay bit; its data is not stored.
- `SHIFT`: on a bit event without `lr_chg`:
  - `sh` <= {`sh[DW-2:0]`, `sd_s2`}, `bitcnt`++.
  - If `bitcnt` = `DW-1` (this is the LSB), complete the word for channel `ch` and go to `HOLD`.
- `SHIFT` on a bit event with `lr_chg`:
  - If `bitcnt` = `DW-1`: the LSB arrives on the transition edge, which is legal for a slot of exactly `DW` SCLKs. Shift in `sd_s2`, complete the word, restart with `bitcnt`=0 and `ch`=`lr_s2`, and stay in `SHIFT`.
  - Otherwise: pulse `ERR`, discard `sh`, restart with `bitcnt`=0 and `ch`=`lr_s2`.
- `HOLD`: ignore padding bits.
  - On a bit event with `lr_chg`, restart with `bitcnt`=0 and `ch`=`lr_s2`, and go to `SHIFT`.

**Word completion**
- Drive the output for channel `ch` with {`sh[DW-2:0]`, `sd_s2`}.
- Pulse the matching `*_VALID` for one cycle.
- The other channel's output and strobe are untouched.

**Reset**
- `L_DOUT`, `R_DOUT`, `L_VALID`, `R_VALID` and `ERR` reset to 0.
- State resets to `SEEK`; `bitcnt`, `sh` and all synchroniser flops reset to 0.
- A reset asserted mid-word discards the partial word. No strobe is issued for it.

**Arithmetic**
- `bitcnt` is `$clog2(DW)` bits wide and never wraps, since it is reset at every restart.
- Data is unsigned bit-transparent with no sign handling.

## Timing

- Let edge k be the `CLK` edge at which `s1` first samples `SCLK` high.
  - Edge k+1: `sclk_rise` becomes true.
  - Edge k+2: the shift, the state update and any `*_DOUT`/`*_VALID`/`ERR` update are registered.
- Latency from the `SCLK` rising edge to the output is therefore 2–3 `CLK` periods.
- `SCLK` high and low phases must each be at least 2 `CLK` periods. The codebase ratio MCLK = 8×SCLK gives 4.
- `SDIN` and `LRCLK` must be stable for at least 2 `CLK` periods around each `SCLK` rise. They share the same synchroniser depth, so they stay aligned with `sclk_rise`.
- `L_VALID` and `R_VALID` are never high in the same cycle. Minimum spacing is one `SCLK` period.
- `ERR` and a `*_VALID` never pulse in the same cycle.
- Throughput is one stereo pair per `LRCLK` period. There is no backpressure; the consumer must accept each strobe.

## Test plan

1. `CLK`/8 `SCLK`, 32 `SCLK` per slot, left 16'hA5C3 and right 16'h1234, 3 frames → `L_DOUT`=A5C3 and `R_DOUT`=1234, 3 pulses each, `ERR`=0, padding ignored.
2. Exact 16-`SCLK` slots, left 16'h8001 and right 16'h7FFE → LSB is captured on the transition edge, outputs are correct and there are no `ERR` pulses.
3. Data streaming before the first `LRCLK` edge after reset → no strobes until the first full slot; first `L_VALID` carries the first complete left word.
4. Left slot shortened to 8 `SCLK`s → one `ERR` pulse, `L_DOUT` keeps its previous value, and the following right word 16'hBEEF is received correctly.
5. `RST` asserted for 1 cycle in the middle of a left word → all outputs are 0 the next cycle, no strobe for the partial word, and normal capture resumes after the next `LRCLK` change.
6. `DW`=24 with 32-`SCLK` slots and left 24'hF0F0F0 → `L_DOUT`=F0F0F0 and the 8 trailing bits are ignored.
